// File: rtl/ppu_mem_arbiter.sv
// Arbitrates the single-port VRAM and OAM RAMs between the CPU, the PPU fetch
// port and the FF46-triggered OAM DMA engine, applying PPU-mode access gating.
module ppu_mem_arbiter #(
  parameter int DMA_BYTE_CYCLES = 4,
  parameter int DMA_LEN         = 160,
  parameter int DMA_START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hit,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [15:0] dma_src_addr,
  output logic        dma_src_rd,
  input  logic [7:0]  dma_src_data,
  output logic        dma_active
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_READ, S_WRITE, S_WAIT} dma_state_t;
  typedef enum logic [1:0] {SRC_FF, SRC_VRAM, SRC_OAM, SRC_REG} rd_src_t;

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0] START_LAST = 8'(DMA_START_DELAY - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(DMA_BYTE_CYCLES - 3);
  localparam bit         HAS_START  = (DMA_START_DELAY > 0);
  localparam bit         HAS_WAIT   = (DMA_BYTE_CYCLES > 2);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ff46_q, ff46_d;
  logic [7:0] src_hi_q, src_hi_d;
  rd_src_t    cpu_src_q, cpu_src_d;
  rd_src_t    ppu_src_q, ppu_src_d;

  logic cpu_is_vram, cpu_is_oam, cpu_is_reg, cpu_acc;
  logic ppu_vram, ppu_oam;
  logic vram_busy, oam_busy;
  logic cpu_vram_ok, cpu_oam_ok;
  logic dma_wr, dma_kick, byte_done;

  assign cpu_is_vram = (cpu_addr[15:13] == 3'b100);
  assign cpu_is_oam  = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
  assign cpu_is_reg  = (cpu_addr == 16'hFF46);
  assign cpu_acc     = cpu_rd || cpu_wr;
  assign cpu_hit     = cpu_is_vram || cpu_is_oam || cpu_is_reg;

  assign ppu_vram = ppu_rd && (ppu_addr[15:13] == 3'b100);
  assign ppu_oam  = ppu_rd && (ppu_addr[15:8] == 8'hFE) && (ppu_addr[7:0] < 8'hA0);

  assign dma_active = (state_q != S_IDLE);
  assign dma_wr     = (state_q == S_WRITE);
  assign dma_kick   = cpu_wr && cpu_is_reg;

  assign vram_busy   = lcd_en && (ppu_mode == 2'd3);
  assign oam_busy    = dma_active || (lcd_en && ppu_mode[1]);
  // The PPU owns a port whenever it reads that memory; a concurrent CPU access is dropped.
  assign cpu_vram_ok = cpu_acc && cpu_is_vram && !vram_busy && !ppu_vram;
  assign cpu_oam_ok  = cpu_acc && cpu_is_oam && !oam_busy && !ppu_oam;

  // Request stage: RAM port muxing
  always_comb begin
    vram_addr  = 13'h0;
    vram_we    = 1'b0;
    vram_wdata = 8'h0;
    if (ppu_vram) begin
      vram_addr = ppu_addr[12:0];
    end else if (cpu_vram_ok) begin
      vram_addr  = cpu_addr[12:0];
      vram_we    = cpu_wr;
      vram_wdata = cpu_wr ? cpu_wdata : 8'h0;
    end

    oam_addr  = 8'h0;
    oam_we    = 1'b0;
    oam_wdata = 8'h0;
    if (dma_wr) begin
      oam_addr  = idx_q;
      oam_we    = (idx_q <= 8'h9F);
      oam_wdata = dma_src_data;
    end else if (ppu_oam) begin
      oam_addr = ppu_addr[7:0];
    end else if (cpu_oam_ok) begin
      oam_addr  = cpu_addr[7:0];
      oam_we    = cpu_wr;
      oam_wdata = cpu_wr ? cpu_wdata : 8'h0;
    end

    dma_src_rd   = (state_q == S_READ);
    dma_src_addr = dma_src_rd ? {src_hi_q, idx_q} : 16'h0;
  end

  always_comb begin
    cpu_src_d = SRC_FF;
    if (cpu_rd) begin
      if (cpu_is_reg)       cpu_src_d = SRC_REG;
      else if (cpu_vram_ok) cpu_src_d = SRC_VRAM;
      else if (cpu_oam_ok)  cpu_src_d = SRC_OAM;
    end
    ppu_src_d = SRC_FF;
    if (ppu_vram)                ppu_src_d = SRC_VRAM;
    else if (ppu_oam && !dma_wr) ppu_src_d = SRC_OAM;
  end

  // DMA sequencer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ff46_d    = ff46_q;
    src_hi_d  = src_hi_q;
    byte_done = 1'b0;
    case (state_q)
      S_START: begin
        if (cnt_q == START_LAST) begin
          state_d = S_READ;
          cnt_d   = 8'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = 8'h0;
        end else begin
          byte_done = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) byte_done = 1'b1;
        else                    cnt_d = cnt_q + 8'h1;
      end
      default: ;
    endcase
    if (byte_done) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 8'h1;
        state_d = S_READ;
      end
    end
    // A new FF46 write always restarts the transfer; echo RAM sources fold down by 0x2000.
    if (dma_kick) begin
      ff46_d   = cpu_wdata;
      src_hi_d = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
      idx_d    = 8'h0;
      cnt_d    = 8'h0;
      state_d  = HAS_START ? S_START : S_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'h0;
      cnt_q     <= 8'h0;
      ff46_q    <= 8'h0;
      cpu_src_q <= SRC_FF;
      ppu_src_q <= SRC_FF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ff46_q    <= ff46_d;
      cpu_src_q <= cpu_src_d;
      ppu_src_q <= ppu_src_d;
    end
    src_hi_q <= src_hi_d;
  end

  // Data stage: source chosen by the grant registered in the request cycle
  always_comb begin
    case (cpu_src_q)
      SRC_VRAM: cpu_rdata = vram_rdata;
      SRC_OAM:  cpu_rdata = oam_rdata;
      SRC_REG:  cpu_rdata = ff46_q;
      default:  cpu_rdata = 8'hFF;
    endcase
    case (ppu_src_q)
      SRC_VRAM: ppu_rdata = vram_rdata;
      SRC_OAM:  ppu_rdata = oam_rdata;
      default:  ppu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Scoreboard bench for ppu_mem_arbiter: a cycle-level reference model pushes
// expected responses; a negedge monitor pops and compares them.
module tb_ppu_mem_arbiter;

  localparam int BC  = 4;
  localparam int DLY = 1;
  localparam int LEN = 160;

  localparam int K_HIT = 0, K_DACT = 1, K_SRC = 2, K_VWE = 3, K_OWE = 4, K_CPU = 5, K_PPU = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ppu_mode;
  logic        lcd_en;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_hit;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata, oam_rdata;
  logic [15:0] dma_src_addr;
  logic        dma_src_rd;
  logic [7:0]  dma_src_data;
  logic        dma_active;

  ppu_mem_arbiter #(.DMA_BYTE_CYCLES(BC), .DMA_LEN(LEN), .DMA_START_DELAY(DLY)) dut (
    .clk(clk), .rst(rst), .ppu_mode(ppu_mode), .lcd_en(lcd_en),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .dma_src_addr(dma_src_addr), .dma_src_rd(dma_src_rd), .dma_src_data(dma_src_data),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source bus contents seen by the DMA
  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_rdata <= vram_mem[vram_addr];
    if (oam_we) oam_mem[oam_addr] <= oam_wdata;
    oam_rdata <= oam_mem[oam_addr];
    dma_src_data <= src_fn(dma_src_addr);
  end

  // Reference model state
  logic [7:0]  ref_vram [8192];
  logic [7:0]  ref_oam  [256];
  logic [7:0]  ref_ff46;
  bit          dma_run;
  int          dma_k;
  logic [15:0] dma_base;

  typedef struct { int due; int kind; logic [31:0] want; } rec_t;
  rec_t sb[$];
  int n_chk = 0, n_fail = 0;

  function automatic string kname(input int k);
    case (k)
      K_HIT:  return "cpu_hit";
      K_DACT: return "dma_active";
      K_SRC:  return "dma_src";
      K_VWE:  return "vram_write";
      K_OWE:  return "oam_write";
      K_CPU:  return "cpu_rdata";
      default: return "ppu_rdata";
    endcase
  endfunction

  task automatic push(input int due, input int kind, input logic [31:0] want);
    rec_t r;
    r.due = due; r.kind = kind; r.want = want;
    sb.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  rec_t        mr;
  logic [31:0] mact;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mr = sb.pop_front();
      case (mr.kind)
        K_HIT:  mact = {31'b0, cpu_hit};
        K_DACT: mact = {31'b0, dma_active};
        K_SRC:  mact = {15'b0, dma_src_rd, dma_src_rd ? dma_src_addr : 16'h0};
        K_VWE:  mact = vram_we ? {10'b0, 1'b1, vram_addr, vram_wdata} : 32'h0;
        K_OWE:  mact = oam_we ? {15'b0, 1'b1, oam_addr, oam_wdata} : 32'h0;
        K_CPU:  mact = {24'b0, cpu_rdata};
        default: mact = {24'b0, ppu_rdata};
      endcase
      n_chk++;
      if (mr.due != cyc || mact !== mr.want) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h", kname(mr.kind), cyc, mr.due, mact, mr.want);
      end
    end
  end

  // Evaluate the current inputs against the model, record expectations, advance one clock.
  task automatic tick();
    int c, rel, bi, vi, oi;
    bit on, src_c, wr_c, is_v, is_o, is_r, pv, po, acc, v_ok, o_ok;
    logic [15:0] fb;
    logic [7:0] e, hi;
    c     = cyc;
    on    = dma_run && (c > dma_k) && (c <= dma_k + DLY + LEN * BC);
    rel   = c - dma_k - DLY - 1;
    src_c = on && rel >= 0 && (rel % BC) == 0;
    wr_c  = on && rel >= 1 && (rel % BC) == 1;
    bi    = (rel >= 0) ? rel / BC : 0;
    fb    = dma_base + 16'(bi);
    is_v  = cpu_addr >= 16'h8000 && cpu_addr <= 16'h9FFF;
    is_o  = cpu_addr >= 16'hFE00 && cpu_addr <= 16'hFE9F;
    is_r  = cpu_addr == 16'hFF46;
    pv    = ppu_rd && ppu_addr >= 16'h8000 && ppu_addr <= 16'h9FFF;
    po    = ppu_rd && ppu_addr >= 16'hFE00 && ppu_addr <= 16'hFE9F;
    acc   = cpu_rd || cpu_wr;
    v_ok  = acc && is_v && !(lcd_en && ppu_mode == 2'd3) && !pv;
    o_ok  = acc && is_o && !on && !(lcd_en && ppu_mode >= 2'd2) && !po;
    vi    = int'(cpu_addr) - 32'h8000;
    oi    = int'(cpu_addr) - 32'hFE00;

    push(c, K_HIT, {31'b0, is_v || is_o || is_r});
    push(c, K_DACT, {31'b0, on});
    push(c, K_SRC, src_c ? {15'b0, 1'b1, fb} : 32'h0);
    push(c, K_VWE, (v_ok && cpu_wr) ? {10'b0, 1'b1, 13'(vi), cpu_wdata} : 32'h0);
    if (wr_c)               push(c, K_OWE, {15'b0, 1'b1, 8'(bi), src_fn(fb)});
    else if (o_ok && cpu_wr) push(c, K_OWE, {15'b0, 1'b1, 8'(oi), cpu_wdata});
    else                    push(c, K_OWE, 32'h0);
    if (cpu_rd) begin
      e = 8'hFF;
      if (is_r)      e = ref_ff46;
      else if (v_ok) e = ref_vram[vi];
      else if (o_ok) e = ref_oam[oi];
      push(c + 1, K_CPU, {24'b0, e});
    end
    if (ppu_rd) begin
      e = 8'hFF;
      if (pv)             e = ref_vram[int'(ppu_addr) - 32'h8000];
      else if (po && !wr_c) e = ref_oam[int'(ppu_addr) - 32'hFE00];
      push(c + 1, K_PPU, {24'b0, e});
    end

    if (v_ok && cpu_wr) ref_vram[vi] = cpu_wdata;
    if (o_ok && cpu_wr) ref_oam[oi] = cpu_wdata;
    if (wr_c) ref_oam[bi] = src_fn(fb);
    if (cpu_wr && is_r) begin
      ref_ff46 = cpu_wdata;
      dma_run  = 1'b1;
      dma_k    = c;
      hi       = (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
      dma_base = {hi, 8'h00};
    end
    if (rst) begin
      dma_run  = 1'b0;
      ref_ff46 = 8'h00;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                    input logic pr, input logic [15:0] pa);
    cpu_rd = r; cpu_wr = w; cpu_addr = a; cpu_wdata = d; ppu_rd = pr; ppu_addr = pa;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
  endtask

  task automatic rand_ops(input int n, input bit vary_mode);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      int k, o;
      if (vary_mode) begin
        ppu_mode = 2'($urandom_range(0, 3));
        lcd_en   = ($urandom_range(0, 3) != 0);
      end
      k = $urandom_range(0, 9);
      case (k)
        0, 1: a = 16'h8000 + 16'($urandom_range(0, 15));
        2:    a = 16'h9FF0 + 16'($urandom_range(0, 15));
        3, 4: a = 16'hFE00 + 16'($urandom_range(0, 15));
        5:    a = 16'hFE90 + 16'($urandom_range(0, 15));
        6:    a = 16'hFEA0 + 16'($urandom_range(0, 15));
        7:    a = 16'hFF46;
        default: a = 16'hC000 + 16'($urandom_range(0, 255));
      endcase
      o = $urandom_range(0, 2);
      if (a == 16'hFF46 && o == 2) o = 1;
      cpu_rd    = (o == 1);
      cpu_wr    = (o == 2);
      cpu_addr  = a;
      cpu_wdata = 8'($urandom_range(0, 255));
      ppu_rd    = ($urandom_range(0, 1) == 1);
      ppu_addr  = ($urandom_range(0, 1) == 1) ? 16'h8000 + 16'($urandom_range(0, 15))
                                              : 16'hFE00 + 16'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic cmp_oam(input string tag);
    for (int i = 0; i < 160; i++) chk(tag, {24'b0, oam_mem[i]}, {24'b0, ref_oam[i]});
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin vram_mem[i] = 8'h00; ref_vram[i] = 8'h00; end
    for (int i = 0; i < 256; i++) begin oam_mem[i] = 8'(i) ^ 8'hA5; ref_oam[i] = 8'(i) ^ 8'hA5; end
    ref_ff46 = 8'h00; dma_run = 1'b0; dma_k = 0; dma_base = 16'h0;
    rst = 1'b1; ppu_mode = 2'd0; lcd_en = 1'b1;
    cpu_addr = 16'h0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h0;
    ppu_rd = 1'b0; ppu_addr = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rdata", {24'b0, cpu_rdata}, 32'hFF);
    chk("rst_ppu_rdata", {24'b0, ppu_rdata}, 32'hFF);
    chk("rst_dma_active", {31'b0, dma_active}, 32'h0);
    chk("rst_strobes", {29'b0, vram_we, oam_we, dma_src_rd}, 32'h0);
    chk("rst_addrs", {dma_src_addr, 3'b0, vram_addr}, 32'h0);
    chk("rst_oam_port", {16'b0, oam_addr, oam_wdata}, 32'h0);
    chk("rst_cpu_hit", {31'b0, cpu_hit}, 32'h0);
    rst = 1'b0;

    // VRAM mode gating
    ppu_mode = 2'd0; lcd_en = 1'b1;
    op(0, 1, 16'h8123, 8'h5A, 0, 16'h0);
    op(1, 0, 16'h8123, 8'h00, 0, 16'h0);
    ppu_mode = 2'd3;
    op(1, 0, 16'h8123, 8'h00, 0, 16'h0);
    op(0, 1, 16'h8123, 8'h77, 0, 16'h0);
    ppu_mode = 2'd0;
    op(1, 0, 16'h8123, 8'h00, 0, 16'h0);
    // OAM mode gating and LCD-off bypass
    ppu_mode = 2'd2;
    op(0, 1, 16'hFE10, 8'h33, 0, 16'h0);
    op(1, 0, 16'hFE10, 8'h00, 0, 16'h0);
    ppu_mode = 2'd1;
    op(0, 1, 16'hFE10, 8'h44, 0, 16'h0);
    op(1, 0, 16'hFE10, 8'h00, 0, 16'h0);
    lcd_en = 1'b0; ppu_mode = 2'd3;
    op(0, 1, 16'h8200, 8'h11, 0, 16'h0);
    op(1, 0, 16'h8200, 8'h00, 0, 16'h0);
    op(0, 1, 16'hFE9F, 8'h22, 0, 16'h0);
    op(1, 0, 16'hFE9F, 8'h00, 0, 16'h0);
    op(1, 0, 16'hFEA0, 8'h00, 0, 16'h0);
    op(1, 0, 16'hFF46, 8'h00, 0, 16'h0);
    // PPU wins the VRAM port over a CPU write
    lcd_en = 1'b1; ppu_mode = 2'd0;
    op(0, 1, 16'h8123, 8'h99, 1, 16'h8123);
    op(1, 0, 16'h8123, 8'h00, 1, 16'h8200);
    idle(2);

    rand_ops(300, 1'b1);
    idle(2);

    // Full transfer with a PPU OAM read colliding with the first DMA write
    op(0, 1, 16'hFF46, 8'hC1, 0, 16'h0);
    idle(DLY + 1);
    op(0, 0, 16'h0, 8'h0, 1, 16'hFE00);
    rand_ops(DLY + LEN * BC + 4, 1'b1);
    idle(2);
    cmp_oam("oam_after_c1");

    // Restart after byte 5 has been written
    op(0, 1, 16'hFF46, 8'hC0, 0, 16'h0);
    rand_ops(DLY + 2 + 5 * BC, 1'b0);
    op(0, 1, 16'hFF46, 8'hD0, 0, 16'h0);
    rand_ops(DLY + LEN * BC + 4, 1'b1);
    idle(2);
    cmp_oam("oam_after_d0");

    // Echo-folded source, reset mid-transfer after byte 50
    op(0, 1, 16'hFF46, 8'hE3, 0, 16'h0);
    rand_ops(DLY + 2 + 50 * BC, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    op(1, 0, 16'hFF46, 8'h00, 1, 16'hFE40);
    idle(3);
    cmp_oam("oam_after_reset");

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
